// File: rtl/tmul_pkg.sv
// Shared types and helpers for the TMUL vector-matrix engine.
package tmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } tmul_state_e;

  function automatic int acc_width(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

  // Fill bit for widening a value: replicated MSB when signed, zero otherwise.
  function automatic logic ext_fill(input logic msb, input logic sgn);
    return sgn & msb;
  endfunction

endpackage

// File: rtl/tmul_mac_lane.sv
// One multiply-accumulate lane: ACC_W accumulator fed by a sign/zero-extended product.
module tmul_mac_lane
  import tmul_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 67
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ACC_W-1:0]  load_val,
  input  logic              en,
  input  logic              signed_en,
  input  logic [DATA_W-1:0] a_k,
  input  logic [DATA_W-1:0] b_ki,
  output logic [ACC_W-1:0]  sum
);

  logic [ACC_W-1:0]    acc;
  logic [2*DATA_W-1:0] a_x;
  logic [2*DATA_W-1:0] b_x;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    prod_ext;

  // Operands widened first, so one modular multiplier covers both signed and unsigned.
  assign a_x  = {{DATA_W{ext_fill(a_k[DATA_W-1], signed_en)}}, a_k};
  assign b_x  = {{DATA_W{ext_fill(b_ki[DATA_W-1], signed_en)}}, b_ki};
  assign prod = a_x * b_x;

  assign prod_ext = {{(ACC_W-2*DATA_W){ext_fill(prod[2*DATA_W-1], signed_en)}}, prod};
  assign sum      = acc + prod_ext;

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= load_val;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/tmul_mv_engine.sv
// Sequential N-lane vector-matrix multiplier: one row of b per cycle, valid/ready on both sides.
//   state | meaning
//   IDLE  | ready for a job; accept latches operands and seeds the accumulators
//   CALC  | one reduction step per cycle, k = 0..N-1
//   DONE  | result held on c with out_valid until out_ready
module tmul_mv_engine
  import tmul_pkg::*;
#(
  parameter int N      = 8,
  parameter int DATA_W = 32,
  parameter int ACC_W  = acc_width(N, DATA_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*DATA_W-1:0]   a,
  input  logic [N*N*DATA_W-1:0] b,
  input  logic                  signed_en,
  input  logic                  acc_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*ACC_W-1:0]    c,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CALC = CALC;
  localparam logic [1:0] S_DONE = DONE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  logic [1:0]        state;
  logic [KW-1:0]     k;
  logic              sgn_q;
  logic [DATA_W-1:0] a_q [N];
  logic [DATA_W-1:0] b_q [N][N];
  logic [ACC_W-1:0]  c_q [N];
  logic [ACC_W-1:0]  lane_sum [N];
  logic              accept;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state == S_CALC);
  assign out_valid = (state == S_DONE);
  assign accept    = in_ready && in_valid;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      assign c[gi*ACC_W +: ACC_W] = c_q[gi];

      tmul_mac_lane #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_lane (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_val  (acc_en ? c_q[gi] : '0),
        .en        (busy),
        .signed_en (sgn_q),
        .a_k       (a_q[k]),
        .b_ki      (b_q[k][gi]),
        .sum       (lane_sum[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      k     <= '0;
      sgn_q <= 1'b0;
      for (int j = 0; j < N; j++) begin
        a_q[j] <= '0;
        c_q[j] <= '0;
        for (int m = 0; m < N; m++) b_q[j][m] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sgn_q <= signed_en;
            k     <= '0;
            for (int j = 0; j < N; j++) begin
              a_q[j] <= a[j*DATA_W +: DATA_W];
              for (int m = 0; m < N; m++) b_q[j][m] <= b[(j*N+m)*DATA_W +: DATA_W];
            end
            state <= S_CALC;
          end
        end
        S_CALC: begin
          k <= k + KW'(1);
          // c is only ever written here, with the final step folded in.
          if (k == KW'(N-1)) begin
            for (int j = 0; j < N; j++) c_q[j] <= lane_sum[j];
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tmul_mv_engine.sv
// Self-checking bench for tmul_mv_engine: cycle-level protocol model plus arithmetic reference.
module tb_tmul_mv_engine;

  localparam int N      = 8;
  localparam int DATA_W = 32;
  localparam int ACC_W  = 67;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [N*DATA_W-1:0]   a;
  logic [N*N*DATA_W-1:0] b;
  logic                  signed_en = 1'b0;
  logic                  acc_en = 1'b0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [N*ACC_W-1:0]    c;
  logic                  busy;

  logic [DATA_W-1:0] av [N];
  logic [DATA_W-1:0] bv [N][N];

  always #5 clk = ~clk;

  always_comb begin
    a = '0;
    b = '0;
    for (int k = 0; k < N; k++) begin
      a[k*DATA_W +: DATA_W] = av[k];
      for (int i = 0; i < N; i++) b[(k*N+i)*DATA_W +: DATA_W] = bv[k][i];
    end
  end

  tmul_mv_engine #(.N(N), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .signed_en (signed_en),
    .acc_en    (acc_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .busy      (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [ACC_W-1:0] lane_c(input int i);
    return c[i*ACC_W +: ACC_W];
  endfunction

  function automatic logic [ACC_W-1:0] ext(input logic [DATA_W-1:0] v, input bit s);
    return s ? {{(ACC_W-DATA_W){v[DATA_W-1]}}, v} : {{(ACC_W-DATA_W){1'b0}}, v};
  endfunction

  // Reference: result = held c (if chaining) + sum of products, all mod 2^ACC_W,
  // visible N edges after acceptance and held until consumed.
  logic [ACC_W-1:0] m_held [N];
  logic [ACC_W-1:0] m_pend [N];
  int m_cnt  = -1;
  bit m_done = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) m_held[i] = '0;
      m_cnt  = -1;
      m_done = 1'b0;
    end else if (m_cnt >= 0) begin
      m_cnt++;
      if (m_cnt == N) begin
        for (int i = 0; i < N; i++) m_held[i] = m_pend[i];
        m_done = 1'b1;
        m_cnt  = -1;
      end
    end else if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (in_valid) begin
      for (int i = 0; i < N; i++) begin
        logic [ACC_W-1:0] s;
        s = acc_en ? m_held[i] : '0;
        for (int k = 0; k < N; k++) s = s + ext(av[k], signed_en) * ext(bv[k][i], signed_en);
        m_pend[i] = s;
      end
      m_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk1("out_valid", out_valid, m_done);
      chk1("in_ready", in_ready, (!m_done && m_cnt < 0));
      chk1("busy", busy, (m_cnt >= 0));
      for (int i = 0; i < N; i++) chk($sformatf("c[%0d]", i), lane_c(i), m_held[i]);
    end
  end

  task automatic set_basic();
    for (int k = 0; k < N; k++) begin
      av[k] = DATA_W'(k + 1);
      for (int i = 0; i < N; i++) bv[k][i] = DATA_W'(i + 1);
    end
  endtask

  task automatic set_const(input logic [DATA_W-1:0] va, input logic [DATA_W-1:0] vb);
    for (int k = 0; k < N; k++) begin
      av[k] = va;
      for (int i = 0; i < N; i++) bv[k][i] = vb;
    end
  endtask

  task automatic scramble();
    for (int k = 0; k < N; k++) begin
      av[k] = $urandom;
      for (int i = 0; i < N; i++) bv[k][i] = $urandom;
    end
    signed_en = 1'($urandom_range(0, 1));
    acc_en    = 1'($urandom_range(0, 1));
  endtask

  task automatic start_job(input bit sgn, input bit acc, output bit ok);
    int w;
    signed_en = sgn;
    acc_en    = acc;
    in_valid  = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    ok = in_ready;
    if (!ok) begin
      chk1("accept_timeout", in_ready, 1'b1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic run_job(input bit sgn, input bit acc, input int bp, output int lat);
    bit ok;
    start_job(sgn, acc, ok);
    lat = -1;
    if (!ok) return;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      chk1("done_timeout", out_valid, 1'b1);
      return;
    end
    for (int j = 0; j < bp; j++) begin
      in_valid = 1'b1;
      scramble();
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk1("ready_after_consume", in_ready, 1'b1);
  endtask

  initial begin
    int lat;
    bit ok;
    set_const('0, '0);
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b1;
    chk_en = 1'b1;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_c0", lane_c(0), '0);

    set_basic();
    run_job(1'b0, 1'b0, 0, lat);
    chk("basic_latency", ACC_W'(lat), ACC_W'(8));
    for (int i = 0; i < N; i++) chk($sformatf("basic_c[%0d]", i), lane_c(i), ACC_W'(36 * (i + 1)));

    set_basic();
    run_job(1'b0, 1'b1, 0, lat);
    for (int i = 0; i < N; i++) chk($sformatf("accum_c[%0d]", i), lane_c(i), ACC_W'(72 * (i + 1)));

    set_const(32'hFFFF_FFFF, 32'd2);
    run_job(1'b1, 1'b0, 0, lat);
    chk("signed_c0", lane_c(0), 67'h7_FFFF_FFFF_FFFF_FFF0);
    chk("signed_c7", lane_c(7), 67'h7_FFFF_FFFF_FFFF_FFF0);

    set_const(32'hFFFF_FFFF, 32'd2);
    run_job(1'b0, 1'b0, 0, lat);
    chk("unsigned_c0", lane_c(0), 67'h0_0000_000F_FFFF_FFF0);
    chk("unsigned_c7", lane_c(7), 67'h0_0000_000F_FFFF_FFF0);

    set_const(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_job(1'b0, 1'b0, 0, lat);
    chk("max_c0", lane_c(0), 67'h7_FFFF_FFF0_0000_0008);
    chk("max_c7", lane_c(7), 67'h7_FFFF_FFF0_0000_0008);

    set_basic();
    run_job(1'b0, 1'b0, 5, lat);
    chk("bp_latency", ACC_W'(lat), ACC_W'(8));
    chk("bp_c0", lane_c(0), ACC_W'(36));
    chk("bp_c7", lane_c(7), ACC_W'(288));

    set_const(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    start_job(1'b0, 1'b0, ok);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk1("mid_busy", busy, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk1("abort_out_valid", out_valid, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_in_ready", in_ready, 1'b1);
    chk("abort_c0", lane_c(0), '0);

    set_basic();
    run_job(1'b0, 1'b0, 0, lat);
    chk("post_abort_c0", lane_c(0), ACC_W'(36));
    chk("post_abort_c7", lane_c(7), ACC_W'(288));

    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < N; k++) begin
        av[k] = $urandom;
        for (int i = 0; i < N; i++) bv[k][i] = $urandom;
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      run_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3), lat);
      chk("rand_latency", ACC_W'(lat), ACC_W'(N));
    end

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
